// File: rtl/gfx256_rw_arbiter.sv
// gfx256_rw_arbiter: round-robin arbiter that shares one gfx256 bus read/write
// port among NREQ graphics requesters. It latches one command per grant and
// inserts an idle cycle (DONE) between transactions.
// Optional: define GFX256_ARB_WDOG_EN to abort a BUSY transaction with an error
// after WDOG_CYCLES cycles without ack/err.
module gfx256_rw_arbiter #(
  parameter int NREQ        = 4,
  parameter int MDW         = 256,
  parameter int AW          = 32,
  parameter int WDOG_CYCLES = 1023
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NREQ-1:0]               req_rd_i,
  input  logic [NREQ-1:0]               req_wr_i,
  input  logic [NREQ-1:0][AW-1:0]       req_addr_i,
  input  logic [NREQ-1:0][MDW/8-1:0]    req_sel_i,
  input  logic [NREQ-1:0][MDW-1:0]      req_dat_i,
  output logic [NREQ-1:0]               req_ack_o,
  output logic [NREQ-1:0]               req_err_o,
  output logic [MDW-1:0]                req_dat_o,
  output logic [NREQ-1:0]               grant_o,
  output logic                          m_read_request_o,
  output logic                          m_write_request_o,
  output logic [AW-1:0]                 m_addr_o,
  output logic [MDW/8-1:0]              m_sel_o,
  output logic [MDW-1:0]                m_dat_o,
  input  logic                          m_ack_i,
  input  logic [MDW-1:0]                m_dat_i,
  input  logic                          m_err_i
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || WDOG_CYCLES < 1) begin : g_param_chk
    $error("gfx256_rw_arbiter: NREQ must be 2..8 and WDOG_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, win, owner;
  logic [NREQ-1:0] req_any;
  logic            win_vld, grant_en, finish, err_fin, rd_cap, wdog_hit;

  assign req_any = req_rd_i | req_wr_i;

  // Round-robin search: lowest offset from ptr (with wrap) wins.
  always_comb begin
    int idx;
    idx     = 0;
    win     = ptr;
    win_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_any[idx]) begin
        win     = PW'(idx);
        win_vld = 1'b1;
      end
    end
  end

`ifdef GFX256_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_cnt;

  // Watchdog counter: cleared on grant, counts every BUSY cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              wdog_cnt <= '0;
    else if (grant_en)        wdog_cnt <= '0;
    else if (state == BUSY)   wdog_cnt <= wdog_cnt + 1'b1;
  end

  // Fires on the edge that ends the WDOG_CYCLES-th BUSY cycle.
  assign wdog_hit = (wdog_cnt == WW'(WDOG_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM next state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    finish    = 1'b0;
    err_fin   = 1'b0;
    rd_cap    = 1'b0;
    case (state)
      IDLE: if (win_vld) begin
        grant_en  = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (m_ack_i || m_err_i) begin
        finish    = 1'b1;
        err_fin   = m_err_i;
        rd_cap    = m_ack_i && !m_err_i && !m_write_request_o;
        state_nxt = DONE;
      end else if (wdog_hit) begin
        finish    = 1'b1;
        err_fin   = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, grant/pointer update, completion pulses and read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr               <= '0;
      owner             <= '0;
      grant_o           <= '0;
      req_ack_o         <= '0;
      req_err_o         <= '0;
      req_dat_o         <= '0;
      m_read_request_o  <= 1'b0;
      m_write_request_o <= 1'b0;
      m_addr_o          <= '0;
      m_sel_o           <= '0;
      m_dat_o           <= '0;
    end else begin
      req_ack_o <= '0;
      req_err_o <= '0;
      if (grant_en) begin
        owner             <= win;
        ptr               <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
        grant_o           <= NREQ'(1) << win;
        m_addr_o          <= req_addr_i[win];
        m_sel_o           <= req_sel_i[win];
        m_dat_o           <= req_dat_i[win];
        // Write wins when a requester raises both directions.
        m_write_request_o <= req_wr_i[win];
        m_read_request_o  <= !req_wr_i[win];
      end
      if (finish) begin
        m_read_request_o   <= 1'b0;
        m_write_request_o  <= 1'b0;
        grant_o            <= '0;
        req_ack_o[owner]   <= 1'b1;
        req_err_o[owner]   <= err_fin;
      end
      if (rd_cap) req_dat_o <= m_dat_i;
    end
  end

endmodule

// File: tb/tb_gfx256_rw_arbiter.sv
// Directed bench for gfx256_rw_arbiter (NREQ=4, MDW=256, AW=32, WDOG_CYCLES=16).
module tb_gfx256_rw_arbiter;
  localparam int NREQ = 4;
  localparam int MDW  = 256;
  localparam int AW   = 32;
  localparam int SW   = MDW / 8;

  logic                     clk, rst_n;
  logic [NREQ-1:0]          req_rd, req_wr;
  logic [NREQ-1:0][AW-1:0]  req_addr;
  logic [NREQ-1:0][SW-1:0]  req_sel;
  logic [NREQ-1:0][MDW-1:0] req_dat;
  logic [NREQ-1:0]          req_ack, req_err, grant;
  logic [MDW-1:0]           req_dat_out;
  logic                     m_rd, m_wr;
  logic [AW-1:0]            m_addr;
  logic [SW-1:0]            m_sel;
  logic [MDW-1:0]           m_dat_out, m_dat_in;
  logic                     m_ack, m_err;

  int n_vec = 0;
  int n_err = 0;

  gfx256_rw_arbiter #(.NREQ(NREQ), .MDW(MDW), .AW(AW), .WDOG_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_rd_i(req_rd), .req_wr_i(req_wr), .req_addr_i(req_addr),
    .req_sel_i(req_sel), .req_dat_i(req_dat),
    .req_ack_o(req_ack), .req_err_o(req_err), .req_dat_o(req_dat_out),
    .grant_o(grant),
    .m_read_request_o(m_rd), .m_write_request_o(m_wr),
    .m_addr_o(m_addr), .m_sel_o(m_sel), .m_dat_o(m_dat_out),
    .m_ack_i(m_ack), .m_dat_i(m_dat_in), .m_err_i(m_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req_rd   = '0;
    req_wr   = '0;
    req_addr = '0;
    req_sel  = '0;
    req_dat  = '0;
    m_ack    = 1'b0;
    m_err    = 1'b0;
    m_dat_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (grant !== 4'b0) begin n_err++; $display("FAIL reset_grant: got %b exp 0", grant); end
    n_vec++; if ({m_rd, m_wr} !== 2'b00) begin n_err++; $display("FAIL reset_mreq: got %b exp 00", {m_rd, m_wr}); end
    n_vec++; if ({req_ack, req_err} !== 8'h00) begin n_err++; $display("FAIL reset_ack_err: got %h exp 00", {req_ack, req_err}); end
    n_vec++; if ({m_addr, m_sel} !== 64'h0) begin n_err++; $display("FAIL reset_addr_sel: got %h exp 0", {m_addr, m_sel}); end
    n_vec++; if ({m_dat_out, req_dat_out} !== 512'h0) begin n_err++; $display("FAIL reset_data: nonzero data outputs"); end
    // stray ack while IDLE must be ignored
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    tick();
    n_vec++; if ({req_ack, grant} !== 8'h00) begin n_err++; $display("FAIL idle_ack_ignored: got %h exp 00", {req_ack, grant}); end
  endtask

  task automatic test_single_read();
    do_reset();
    req_addr[0] = 32'h0000_1000;
    req_rd      = 4'b0001;
    tick();  // grant edge
    n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL rd_grant: got %b exp 0001", grant); end
    n_vec++; if ({m_rd, m_wr} !== 2'b10) begin n_err++; $display("FAIL rd_dir: got %b exp 10", {m_rd, m_wr}); end
    n_vec++; if (m_addr !== 32'h0000_1000) begin n_err++; $display("FAIL rd_addr: got %h exp 00001000", m_addr); end
    tick();
    tick();
    n_vec++; if (m_rd !== 1'b1) begin n_err++; $display("FAIL rd_hold: got %b exp 1", m_rd); end
    m_ack    = 1'b1;
    m_dat_in = {32{8'hA5}};
    tick();  // ack sampled 3 cycles after request edge
    m_ack  = 1'b0;
    req_rd = '0;
    n_vec++; if (req_ack !== 4'b0001) begin n_err++; $display("FAIL rd_ack: got %b exp 0001", req_ack); end
    n_vec++; if (req_dat_out !== {32{8'hA5}}) begin n_err++; $display("FAIL rd_data: got %h exp a5..a5", req_dat_out); end
    n_vec++; if ({m_rd, grant} !== 5'b0) begin n_err++; $display("FAIL rd_release: got %b exp 00000", {m_rd, grant}); end
    tick();
    n_vec++; if (req_ack !== 4'b0) begin n_err++; $display("FAIL rd_ack_pulse: got %b exp 0000", req_ack); end
  endtask

  task automatic test_round_robin();
    int gq[$];
    int aq[$];
    logic [NREQ-1:0] av[$];
    logic [NREQ-1:0] gprev;
    int bcnt;
    do_reset();
    req_rd = 4'b1111;
    gprev  = '0;
    bcnt   = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      // bus answers with a registered ack one cycle after seeing the request
      if (m_rd || m_wr) bcnt++; else bcnt = 0;
      m_ack = (bcnt == 2);
      if (grant != 0 && gprev == 0)
        for (int i = 0; i < NREQ; i++) if (grant[i]) gq.push_back(i);
      if (req_ack != 0) begin aq.push_back(c); av.push_back(req_ack); end
      gprev = grant;
      if (gq.size() >= 5 && aq.size() >= 5) break;
    end
    req_rd = '0;
    m_ack  = 1'b0;
    n_vec++;
    if (gq.size() < 5 || aq.size() < 5) begin
      n_err++; $display("FAIL rr_progress: grants %0d acks %0d exp 5 each", gq.size(), aq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_vec++; if (gq[i] !== (i % NREQ)) begin n_err++; $display("FAIL rr_order[%0d]: got %0d exp %0d", i, gq[i], i % NREQ); end
        n_vec++; if (av[i] !== (4'b0001 << (i % NREQ))) begin n_err++; $display("FAIL rr_ack_owner[%0d]: got %b exp %b", i, av[i], 4'b0001 << (i % NREQ)); end
      end
      for (int i = 0; i < 4; i++) begin
        n_vec++; if (aq[i+1] - aq[i] !== 4) begin n_err++; $display("FAIL rr_period[%0d]: got %0d exp 4", i, aq[i+1] - aq[i]); end
      end
    end
    tick();
    tick();
  endtask

  task automatic test_rd_wr_priority();
    do_reset();
    req_sel[2] = 32'h0000_00FF;
    req_dat[2] = {8{32'h1122_3344}};
    req_addr[2] = 32'h0000_2200;
    req_rd = 4'b0100;
    req_wr = 4'b0100;
    tick();
    n_vec++; if (grant !== 4'b0100) begin n_err++; $display("FAIL rw_grant: got %b exp 0100", grant); end
    n_vec++; if ({m_rd, m_wr} !== 2'b01) begin n_err++; $display("FAIL rw_dir: got %b exp 01", {m_rd, m_wr}); end
    n_vec++; if (m_sel !== 32'h0000_00FF) begin n_err++; $display("FAIL rw_sel: got %h exp 000000ff", m_sel); end
    n_vec++; if (m_dat_out !== {8{32'h1122_3344}}) begin n_err++; $display("FAIL rw_data: got %h", m_dat_out); end
    m_ack    = 1'b1;
    m_dat_in = {8{32'hDEAD_BEEF}};
    tick();
    m_ack  = 1'b0;
    req_rd = '0;
    req_wr = '0;
    n_vec++; if (req_ack !== 4'b0100) begin n_err++; $display("FAIL rw_ack: got %b exp 0100", req_ack); end
    n_vec++; if (req_dat_out !== '0) begin n_err++; $display("FAIL rw_rdata_hold: got %h exp 0", req_dat_out); end
    tick();
  endtask

  task automatic test_drop_mid_busy();
    do_reset();
    req_addr[3] = 32'h0000_3000;
    req_rd = 4'b1000;
    tick();
    n_vec++; if (grant !== 4'b1000) begin n_err++; $display("FAIL drop_grant: got %b exp 1000", grant); end
    req_rd      = '0;
    req_addr[3] = 32'hFFFF_0000;
    tick();
    n_vec++; if (m_addr !== 32'h0000_3000) begin n_err++; $display("FAIL drop_addr_stable: got %h exp 00003000", m_addr); end
    n_vec++; if ({m_rd, grant} !== 5'b11000) begin n_err++; $display("FAIL drop_still_busy: got %b exp 11000", {m_rd, grant}); end
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    n_vec++; if (req_ack !== 4'b1000) begin n_err++; $display("FAIL drop_ack: got %b exp 1000", req_ack); end
    tick();
  endtask

  task automatic test_error();
    do_reset();
    req_addr[1] = 32'h0000_2000;
    req_rd = 4'b0010;
    tick();
    m_ack    = 1'b1;
    m_dat_in = {32{8'h5A}};
    tick();  // good read, request stays high as a new command
    m_ack = 1'b0;
    n_vec++; if (req_dat_out !== {32{8'h5A}}) begin n_err++; $display("FAIL err_prime: got %h exp 5a..5a", req_dat_out); end
    tick();  // DONE
    tick();  // regrant
    n_vec++; if (grant !== 4'b0010) begin n_err++; $display("FAIL err_regrant: got %b exp 0010", grant); end
    m_err    = 1'b1;
    m_dat_in = {32{8'hFF}};
    tick();
    m_err  = 1'b0;
    req_rd = '0;
    n_vec++; if ({req_ack, req_err} !== 8'b0010_0010) begin n_err++; $display("FAIL err_pulse: got %b exp 00100010", {req_ack, req_err}); end
    n_vec++; if (req_dat_out !== {32{8'h5A}}) begin n_err++; $display("FAIL err_rdata_hold: got %h exp 5a..5a", req_dat_out); end
    tick();
  endtask

  task automatic test_watchdog();
    int n;
    do_reset();
    req_rd = 4'b0001;
    tick();
    req_rd = '0;
`ifdef GFX256_ARB_WDOG_EN
    n = 0;
    while (req_ack == 0 && n < 40) begin
      tick();
      n++;
    end
    n_vec++; if (n !== 16) begin n_err++; $display("FAIL wdog_latency: got %0d exp 16", n); end
    n_vec++; if ({req_ack, req_err} !== 8'b0001_0001) begin n_err++; $display("FAIL wdog_err: got %b exp 00010001", {req_ack, req_err}); end
    n_vec++; if (req_dat_out !== '0) begin n_err++; $display("FAIL wdog_rdata: got %h exp 0", req_dat_out); end
    m_ack = 1'b1;  // late ack after abort
    tick();
    m_ack = 1'b0;
    n_vec++; if (req_ack !== 4'b0) begin n_err++; $display("FAIL wdog_late_ack: got %b exp 0000", req_ack); end
`else
    n = 0;
    while (req_ack == 0 && n < 40) begin
      tick();
      n++;
    end
    n_vec++; if (n !== 40 || grant !== 4'b0001) begin n_err++; $display("FAIL no_wdog_wait: ack after %0d grant %b exp 40 0001", n, grant); end
`endif
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    req_wr      = 4'b0100;
    req_addr[2] = 32'h0000_4444;
    req_sel[2]  = '1;
    req_dat[2]  = {8{32'hCAFE_F00D}};
    tick();
    tick();
    n_vec++; if ({m_wr, grant} !== 5'b10100) begin n_err++; $display("FAIL rst_pre: got %b exp 10100", {m_wr, grant}); end
    rst_n = 1'b0;
    #1;
    n_vec++; if ({m_rd, m_wr, grant, req_ack, req_err} !== 14'b0) begin n_err++; $display("FAIL rst_async_ctl: got %b exp 0", {m_rd, m_wr, grant, req_ack, req_err}); end
    n_vec++; if ({m_addr, m_sel} !== 64'h0 || m_dat_out !== '0) begin n_err++; $display("FAIL rst_async_data: got %h exp 0", {m_addr, m_sel}); end
    req_wr = '0;
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++; if (req_ack !== 4'b0) begin n_err++; $display("FAIL rst_no_ack: got %b exp 0000", req_ack); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_rd_wr_priority();
    test_drop_mid_busy();
    test_error();
    test_watchdog();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gfx256_rw_arbiter.md
Name: gfx256_rw_arbiter

Overview:
- Shares the single gfx256 asynchronous bus read/write port among NREQ graphics requesters (texture fetch, Z read/write, colour write, blitter).
- Sits directly in front of the bus port. It drives that port's level-sensitive read/write request, address, sel and data, and consumes its one-cycle ack pulse and returned data.
- Latches one command per grant and holds it stable until ack. Arbitration is round-robin, and the block guarantees the idle gap the bus port needs between transactions.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MDW, 256, data width in bits; sel width is MDW/8.
- AW, 32, address width.
- WDOG_CYCLES, 1023, watchdog limit in cycles; only used when GFX256_ARB_WDOG_EN is defined.

Ports:
- clk_i  in  1  master clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_rd_i  in  NREQ  per-requester read request (level).
- req_wr_i  in  NREQ  per-requester write request (level).
- req_addr_i  in  NREQ*AW  per-requester byte address.
- req_sel_i  in  NREQ*MDW/8  per-requester byte lane selects.
- req_dat_i  in  NREQ*MDW  per-requester write data.
- req_ack_o  out  NREQ  one-cycle completion pulse to the owning requester.
- req_err_o  out  NREQ  one-cycle error pulse; coincides with req_ack_o.
- req_dat_o  out  MDW  read data (shared); valid in the req_ack_o cycle.
- grant_o  out  NREQ  one-hot current owner; 0 when idle.
- m_read_request_o  out  1  to bus port read_request.
- m_write_request_o  out  1  to bus port write_request.
- m_addr_o  out  AW  to bus port address.
- m_sel_o  out  MDW/8  to bus port sel.
- m_dat_o  out  MDW  to bus port write data.
- m_ack_i  in  1  bus port data ack, one-cycle pulse.
- m_dat_i  in  MDW  bus port read data.
- m_err_i  in  1  bus error (sint) from the bus port.

Behaviour:
- Reset (async, rst_ni=0): all outputs 0, state IDLE, round-robin pointer 0, command latch 0.
- States:
  - IDLE: with any req_rd_i|req_wr_i set, pick a winner. The search starts at the pointer, ascends and wraps at NREQ-1 -> 0.
    - On the next edge: latch the winner's addr/sel/dat and direction; set grant_o one-hot; assert m_read_request_o or m_write_request_o; go to BUSY; pointer <= winner+1 mod NREQ.
    - If both rd and wr are set for the winner, the write is performed; the read is ignored.
  - BUSY: m_* outputs are driven only from the latch, so they stay stable whatever the requester does.
    - On m_ack_i or m_err_i: next edge drops both m_*_request_o, clears grant_o, pulses req_ack_o[owner] for 1 cycle, and goes to DONE.
    - req_dat_o <= m_dat_i on reads; it holds its previous value on writes.
    - If m_err_i, req_err_o[owner] pulses in the same cycle as req_ack_o.
  - DONE: 1 cycle with requests low, so the bus port returns to its wait state. Then go to IDLE.
- Latency:
  - Request seen in IDLE at edge N -> m request high after N.
  - Ack at edge M -> req_ack_o high for the cycle after M.
  - Next grant is issued no earlier than M+2.
  - Minimum back-to-back transaction period is 4 cycles with a 1-cycle bus.
- A requester dropping its request while owned does not abort the transaction: it completes, and ack is still pulsed to that requester.
- Requesters must deassert their request (or present a new command) in the cycle req_ack_o is high. A request still high in IDLE is treated as a new request.
- m_ack_i outside BUSY is ignored.
- Round-robin fairness: a requester held active is granted at least once every NREQ transactions.
- Async reset mid-transaction: everything returns to reset values immediately, with no ack generated.

Optional Feature:
- Macro: GFX256_ARB_WDOG_EN.
- Defined:
  - A cycle counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches WDOG_CYCLES without m_ack_i/m_err_i, the transaction is treated as errored: req_ack_o and req_err_o pulse to the owner, req_dat_o is unchanged, and the state goes to DONE.
  - A late m_ack_i arriving after the abort is ignored.
- Not defined: no counter; BUSY waits indefinitely for ack/err.

Test Plan:
- Single read: req_rd_i=0001, addr 0x0000_1000; bus acks 3 cycles after the request with m_dat_i=0xA5..A5 -> m_read_request_o high until the cycle after ack, req_ack_o[0] 1 cycle with req_dat_o=0xA5..A5, grant_o back to 0.
- Round-robin: req_rd_i=1111 held, 1-cycle acks -> grant order 0,1,2,3,0 and 4 cycles between successive req_ack_o pulses.
- Rd+wr both set on requester 2, sel=0x0000_00FF, dat=0x1122.. -> m_write_request_o=1, m_read_request_o=0, m_sel_o=0x0000_00FF.
- Requester drops its request and changes req_addr_i mid-BUSY -> m_addr_o unchanged and ack still delivered to that requester.
- Error: m_err_i pulse in BUSY for requester 1 -> req_ack_o[1] and req_err_o[1] high in the same cycle, req_dat_o unchanged.
- With GFX256_ARB_WDOG_EN and WDOG_CYCLES=16, no ack -> req_err_o pulses after 16 BUSY cycles; a later m_ack_i produces no req_ack_o. Separately, rst_ni low mid-BUSY -> all outputs 0 immediately.
